lcd_ctrl: RTL and testbench

- Hardware sequencer for the HD44780-compatible character LCD in 4-bit mode. It replaces CPU bit-banging of E/RS/DB.
- The CPU pushes command/data bytes into a 4-entry FIFO. The block produces the E strobe, nibble ordering, setup/hold and post-command wait timing.
- It sits in the board top beside the memory-mapped IO registers. The top decodes the bus write to this block's address into wr_en/wr_data and returns status on reads.

---
 rtl/lcd_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit mode sequencer: a 4-entry command/data FIFO drained
// by an E-strobe FSM with setup, pulse, hold and post-command waits.
module lcd_ctrl #(
    parameter int T_AS   = 2,
    parameter int T_PW   = 13,
    parameter int T_H    = 2,
    parameter int T_CMD  = 1080,
    parameter int T_LONG = 44000,
    parameter int CNT_W  = 17
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [9:0] wr_data,
    input  logic       clr_ovf,
    output logic [7:0] status,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    localparam logic [CNT_W-1:0] L_AS   = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] L_PW   = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] L_H    = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] L_CMD  = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] L_LONG = CNT_W'(T_LONG - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

    logic [9:0]       r_mem [4];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [2:0]       r_count;
    logic             r_ovf;

    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             r_second;
    logic             w_second_n;
    logic             r_long;
    logic             w_long_n;
    logic [3:0]       r_lo;
    logic [3:0]       w_lo_n;
    logic             r_e;
    logic             w_e_n;
    logic             r_rs;
    logic             w_rs_n;
    logic [3:0]       r_db;
    logic [3:0]       w_db_n;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [9:0]       w_head;
    logic             w_is_long;

    assign w_full = (r_count == 3'd4);
    assign w_push = wr_en & ~w_full;
    assign w_head = r_mem[r_rptr];

    // Clear display (0x01) and return home (0x02/0x03) need the long wait
    assign w_is_long = ~w_head[9] & ~w_head[8]
                     & (w_head[7:2] == 6'd0)
                     & (w_head[1:0] != 2'd0);

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_second_n = r_second;
        w_long_n   = r_long;
        w_lo_n     = r_lo;
        w_e_n      = r_e;
        w_rs_n     = r_rs;
        w_db_n     = r_db;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_count != 3'd0) begin
                    w_pop      = 1'b1;
                    w_state_n  = SETUP;
                    w_cnt_n    = L_AS;
                    w_rs_n     = w_head[8];
                    w_db_n     = w_head[7:4];
                    w_lo_n     = w_head[3:0];
                    w_second_n = ~w_head[9];
                    w_long_n   = w_is_long;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_n = PULSE;
                    w_cnt_n   = L_PW;
                    w_e_n     = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_state_n = HOLD;
                    w_cnt_n   = L_H;
                    w_e_n     = 1'b0;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    if (r_second) begin
                        w_second_n = 1'b0;
                        w_db_n     = r_lo;
                        w_state_n  = SETUP;
                        w_cnt_n    = L_AS;
                    end else begin
                        w_state_n = WAIT;
                        w_cnt_n   = r_long ? L_LONG : L_CMD;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_second <= 1'b0;
            r_long   <= 1'b0;
            r_lo     <= 4'd0;
            r_e      <= 1'b0;
            r_rs     <= 1'b0;
            r_db     <= 4'd0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_second <= w_second_n;
            r_long   <= w_long_n;
            r_lo     <= w_lo_n;
            r_e      <= w_e_n;
            r_rs     <= w_rs_n;
            r_db     <= w_db_n;
        end
    end

    assign busy   = (r_count != 3'd0) | (r_state != IDLE);
    assign status = {r_ovf, w_full, busy, 2'b00, r_count};
    assign lcd_e  = r_e;
    assign lcd_rs = r_rs;
    assign lcd_rw = 1'b0;
    assign lcd_db = r_db;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected {rs,db} per E pulse is
// queued at push time and popped by a monitor on each E rising edge.
module tb_lcd_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [9:0] wr_data = 10'd0;
    logic       clr_ovf = 1'b0;
    logic [7:0] status;
    logic       busy;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_db;

    int checks   = 0;
    int failures = 0;

    logic [4:0] sb [$];
    int         rises [$];
    int         falls [$];
    logic       rsk [0:511];
    logic [3:0] dbk [0:511];

    lcd_ctrl #(
        .T_AS  (2),
        .T_PW  (3),
        .T_H   (2),
        .T_CMD (5),
        .T_LONG(20),
        .CNT_W (17)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .clr_ovf(clr_ovf),
        .status (status),
        .busy   (busy),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_db (lcd_db)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected pulses for one entry: high nibble, then low unless nib_only
    task automatic expect_entry(input logic [9:0] d);
        sb.push_back({d[8], d[7:4]});
        if (!d[9]) begin
            sb.push_back({d[8], d[3:0]});
        end
    endtask

    task automatic push(input logic [9:0] d, input bit accepted);
        @(negedge sys_clk);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) begin
            expect_entry(d);
        end
        @(posedge sys_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic trace(input int maxk, output int idle_k);
        logic pe;
        rises.delete();
        falls.delete();
        idle_k = -1;
        pe     = lcd_e;
        for (int k = 1; k <= maxk; k++) begin
            @(posedge sys_clk);
            #1;
            rsk[k] = lcd_rs;
            dbk[k] = lcd_db;
            if (lcd_e && !pe) rises.push_back(k);
            if (!lcd_e && pe) falls.push_back(k);
            pe = lcd_e;
            if (!busy) begin
                idle_k = k;
                break;
            end
        end
    endtask

    initial begin : monitor
        logic       pe;
        logic [4:0] exp;
        pe = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (lcd_e && !pe) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse actual=%0h expected=none",
                             {lcd_rs, lcd_db});
                end else begin
                    exp = sb.pop_front();
                    if ({lcd_rs, lcd_db} != exp) begin
                        failures++;
                        $display("FAIL pulse_rs_db actual=%0h expected=%0h",
                                 {lcd_rs, lcd_db}, exp);
                    end
                end
            end
            pe = lcd_e;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int idle_k;
        int n;

        #2;
        chk("rst_lcd_e", int'(lcd_e), 0);
        chk("rst_lcd_rs", int'(lcd_rs), 0);
        chk("rst_lcd_db", int'(lcd_db), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_busy", int'(busy), 0);
        chk("lcd_rw", int'(lcd_rw), 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Data byte 'A' with rs=1
        push(10'h141, 1'b1);
        trace(100, idle_k);
        chk("t1_rs_e1", int'(rsk[1]), 1);
        chk("t1_db_e1", int'(dbk[1]), 4);
        chk("t1_db_e8", int'(dbk[8]), 1);
        chk("t1_npulse", rises.size(), 2);
        chk("t1_nfall", falls.size(), 2);
        if (rises.size() == 2 && falls.size() == 2) begin
            chk("t1_rise0", rises[0], 3);
            chk("t1_fall0", falls[0], 6);
            chk("t1_rise1", rises[1], 10);
            chk("t1_fall1", falls[1], 13);
        end
        chk("t1_idle", idle_k, 20);
        chk("t1_status", int'(status), 0);

        // Clear display uses the long wait
        push(10'h001, 1'b1);
        trace(100, idle_k);
        chk("t2_idle_long", idle_k, 35);

        // Entry mode set uses the normal wait
        push(10'h006, 1'b1);
        trace(100, idle_k);
        chk("t3_idle_cmd", idle_k, 20);

        // Single-nibble init entry
        push(10'h230, 1'b1);
        trace(100, idle_k);
        chk("t4_npulse", rises.size(), 1);
        chk("t4_rs", int'(rsk[1]), 0);
        chk("t4_db", int'(dbk[1]), 3);
        chk("t4_idle", idle_k, 13);

        // Push on the pop edge keeps count at 1
        push(10'h148, 1'b1);
        push(10'h149, 1'b1);
        chk("t5_count", int'(status[2:0]), 1);
        trace(200, idle_k);
        chk("t5_idle_seen", int'(idle_k > 0), 1);

        // Six back-to-back pushes: the sixth overflows
        for (int i = 0; i < 6; i++) begin
            push(10'h150 + 10'(i), i < 5);
        end
        chk("t6_status", int'(status), 8'hE4);
        trace(400, idle_k);
        chk("t6_idle_seen", int'(idle_k > 0), 1);
        chk("t6_ovf_sticky", int'(status[7]), 1);
        @(negedge sys_clk);
        clr_ovf = 1'b1;
        @(posedge sys_clk);
        #1;
        clr_ovf = 1'b0;
        chk("t6_ovf_clr", int'(status), 0);
        chk("sb_drained", sb.size(), 0);

        // Reset while E is high discards everything
        push(10'h141, 1'b1);
        push(10'h142, 1'b1);
        n = 0;
        while (!lcd_e && n < 20) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk("t7_e_high", int'(lcd_e), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_e_drop", int'(lcd_e), 0);
        chk("t7_count", int'(status[2:0]), 0);
        chk("t7_busy", int'(busy), 0);
        sb.delete();
        @(negedge sys_clk);
        rst_n = 1'b1;
        trace(30, idle_k);
        chk("t7_no_pulse", rises.size(), 0);
        chk("t7_idle", idle_k, 1);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
